lfsr_tpg: RTL and testbench

//  Parametrised LFSR test-pattern generator for BIST sequences. Run-time polynomial, seed load,

---
 rtl/lfsr_pkg.sv | 13 +
 rtl/lfsr_next.sv | 25 ++
 rtl/lfsr_tpg.sv | 121 ++++++++++++
 tb/tb_lfsr_tpg.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and constants for the LFSR test-pattern generator and its future MISR sibling.
package lfsr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } fsm_e;

    localparam logic MODE_FIB = 1'b0;
    localparam logic MODE_GAL = 1'b1;

endpackage

// File: rtl/lfsr_next.sv
// Combinational LFSR step: Fibonacci (feedback into MSB) or Galois (tap mask XORed on LSB out).
module lfsr_next
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_state,
    input  logic [WIDTH-1:0] i_poly,
    input  logic             i_mode,
    output logic [WIDTH-1:0] o_next
);

    logic w_fb;

    assign w_fb = ^(i_state & i_poly);

    always_comb begin
        if (i_mode == MODE_GAL) begin
            o_next = {1'b0, i_state[WIDTH-1:1]} ^ ({WIDTH{i_state[0]}} & i_poly);
        end else begin
            o_next = {w_fb, i_state[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/lfsr_tpg.sv
// BIST pattern generator: run-time polynomial LFSR with seed load, pattern count and
// START/BUSY/DONE handshake. An all-zero next state is replaced by DEF_SEED and flagged.
module lfsr_tpg
    import lfsr_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               CNT_W    = 16,
    parameter logic [WIDTH-1:0] DEF_SEED = {WIDTH{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic             i_seed_ld,
    input  logic [WIDTH-1:0] i_seed,
    input  logic [WIDTH-1:0] i_poly,
    input  logic             i_mode,
    input  logic [CNT_W-1:0] i_num_pat,
    output logic [WIDTH-1:0] o_pattern,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_lockup
);

    fsm_e             r_fsm;
    fsm_e             w_fsm_nxt;
    logic [WIDTH-1:0] r_state;
    logic [WIDTH-1:0] r_poly;
    logic             r_mode;
    logic [CNT_W-1:0] r_cnt;
    logic             r_lockup;
    logic [WIDTH-1:0] w_next;
    logic [CNT_W-1:0] w_last;

    lfsr_next #(.WIDTH(WIDTH)) u_next (
        .i_state (r_state),
        .i_poly  (r_poly),
        .i_mode  (r_mode),
        .o_next  (w_next)
    );

    assign w_last = i_num_pat - CNT_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_fsm <= ST_IDLE;
        end else begin
            r_fsm <= w_fsm_nxt;
        end
    end

    // NOTE: next state gets a default first, so no path through this block can infer a latch.
    always_comb begin
        w_fsm_nxt = r_fsm;
        unique case (r_fsm)
            ST_IDLE: begin
                if (i_start) begin
                    w_fsm_nxt = (i_num_pat == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_abort) begin
                    w_fsm_nxt = ST_IDLE;
                end else if (r_cnt == w_last) begin
                    w_fsm_nxt = ST_FIN;
                end
            end
            ST_FIN:  w_fsm_nxt = ST_IDLE;
            default: w_fsm_nxt = ST_IDLE;
        endcase
    end

    // A zero seed in IDLE sets LOCKUP even when START is accepted at the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state  <= DEF_SEED;
            r_poly   <= '0;
            r_mode   <= MODE_FIB;
            r_cnt    <= '0;
            r_lockup <= 1'b0;
        end else begin
            unique case (r_fsm)
                ST_IDLE: begin
                    if (i_start) begin
                        r_poly   <= i_poly;
                        r_mode   <= i_mode;
                        r_cnt    <= '0;
                        r_lockup <= 1'b0;
                    end
                    if (i_seed_ld) begin
                        if (i_seed == '0) begin
                            r_state  <= DEF_SEED;
                            r_lockup <= 1'b1;
                        end else begin
                            r_state <= i_seed;
                        end
                    end
                end
                ST_RUN: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_next == '0) begin
                        r_state  <= DEF_SEED;
                        r_lockup <= 1'b1;
                    end else begin
                        r_state <= w_next;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_pattern = r_state;
    assign o_valid   = (r_fsm == ST_RUN);
    assign o_busy    = (r_fsm != ST_IDLE);
    assign o_done    = (r_fsm == ST_FIN);
    assign o_lockup  = r_lockup;

endmodule

// File: tb/tb_lfsr_tpg.sv
// Bench for lfsr_tpg: directed and random runs on a 4-bit instance, period sweep on an 8-bit one.
module tb_lfsr_tpg;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start, abort, seed_ld, mode;
    logic [3:0]  seed, poly;
    logic [15:0] num_pat;
    logic [3:0]  pattern;
    logic        valid, busy, done, lockup;

    logic        start8;
    logic [7:0]  poly8;
    logic [15:0] num_pat8;
    logic [7:0]  pattern8;
    logic        valid8, busy8, done8, lockup8;
    logic        zero1 = 1'b0;
    logic [7:0]  zero8 = 8'h00;

    lfsr_tpg #(.WIDTH(4), .CNT_W(16), .DEF_SEED(4'hF)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_abort(abort),
        .i_seed_ld(seed_ld), .i_seed(seed), .i_poly(poly), .i_mode(mode),
        .i_num_pat(num_pat), .o_pattern(pattern), .o_valid(valid),
        .o_busy(busy), .o_done(done), .o_lockup(lockup)
    );

    lfsr_tpg #(.WIDTH(8), .CNT_W(16), .DEF_SEED(8'hFF)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start8), .i_abort(zero1),
        .i_seed_ld(zero1), .i_seed(zero8), .i_poly(poly8), .i_mode(zero1),
        .i_num_pat(num_pat8), .o_pattern(pattern8), .o_valid(valid8),
        .o_busy(busy8), .o_done(done8), .o_lockup(lockup8)
    );

    int total = 0;
    int bad   = 0;

    logic [3:0] m_state;
    bit         m_lockup;
    logic [3:0] obs[$];
    bit         seen[256];

    logic [3:0] exp_fib[15] = '{4'hF, 4'h7, 4'h3, 4'h1, 4'h8, 4'h4, 4'h2, 4'h9,
                                4'hC, 4'h6, 4'hB, 4'h5, 4'hA, 4'hD, 4'hE};
    logic [3:0] exp_gal[15] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                                4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2};
    logic [3:0] exp_lock[3] = '{4'h1, 4'hF, 4'h7};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference step straight from the shift/tap rules, using plain arithmetic on integers.
    function automatic logic [7:0] ref_next(input logic [7:0] s, input logic [7:0] p,
                                            input bit gal, input int w);
        int parity;
        int r;
        if (!gal) begin
            parity = $countones(s & p) % 2;
            r = (int'(s) / 2) + parity * (1 << (w - 1));
        end else begin
            r = (int'(s) / 2) ^ ((int'(s) % 2 == 1) ? int'(p) : 0);
        end
        return 8'(r);
    endfunction

    task automatic model_advance(input logic [3:0] p, input bit md);
        logic [7:0] nx;
        nx = ref_next({4'h0, m_state}, {4'h0, p}, md, 4);
        if (nx == 8'h00) begin
            m_state  = 4'hF;
            m_lockup = 1'b1;
        end else begin
            m_state = nx[3:0];
        end
    endtask

    // One run on the 4-bit instance; abort_at/start_at/rst_at pick a VALID cycle index (-1 = never).
    task automatic run(input bit sld, input logic [3:0] sd, input logic [3:0] p, input bit md,
                       input logic [15:0] n, input int abort_at, input int start_at, input int rst_at);
        obs.delete();
        seed_ld = sld; seed = sd; poly = p; mode = md; num_pat = n; start = 1'b1;
        m_lockup = 1'b0;
        if (sld) begin
            if (sd == 4'h0) begin
                m_state  = 4'hF;
                m_lockup = 1'b1;
            end else begin
                m_state = sd;
            end
        end
        step();
        start = 1'b0; seed_ld = 1'b0;
        if (n == 16'd0) begin
            check("zero_valid", valid, 0);
            check("zero_done", done, 1);
            check("zero_lockup", lockup, m_lockup);
            step();
            check("zero_busy", busy, 0);
            check("zero_done_off", done, 0);
            return;
        end
        for (int k = 0; k < int'(n); k++) begin
            check("valid", valid, 1);
            check("busy", busy, 1);
            check("pattern", pattern, m_state);
            obs.push_back(pattern);
            if (k == abort_at) abort = 1'b1;
            if (k == start_at) begin
                start = 1'b1; seed_ld = 1'b1; seed = ~m_state; poly = ~p; mode = ~md;
            end
            if (k == rst_at) rst_n = 1'b0;
            step();
            start = 1'b0; seed_ld = 1'b0; poly = p; mode = md;
            if (k == rst_at) begin
                rst_n = 1'b1;
                m_state = 4'hF; m_lockup = 1'b0;
                check("rst_pattern", pattern, 4'hF);
                check("rst_valid", valid, 0);
                check("rst_busy", busy, 0);
                check("rst_done", done, 0);
                check("rst_lockup", lockup, 0);
                return;
            end
            model_advance(p, md);
            check("lockup", lockup, m_lockup);
            if (k == abort_at) begin
                abort = 1'b0;
                check("abort_busy", busy, 0);
                check("abort_done", done, 0);
                check("abort_pattern", pattern, m_state);
                return;
            end
        end
        check("fin_done", done, 1);
        check("fin_valid", valid, 0);
        check("fin_busy", busy, 1);
        check("fin_pattern", pattern, m_state);
        step();
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_pattern", pattern, m_state);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ms;
        int distinct;
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; seed_ld = 1'b0; mode = 1'b0;
        seed = 4'h0; poly = 4'h0; num_pat = 16'd0;
        start8 = 1'b0; poly8 = 8'h00; num_pat8 = 16'd0;
        step(); step();
        rst_n = 1'b1;
        check("reset_pattern", pattern, 4'hF);
        check("reset_valid", valid, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_lockup", lockup, 0);
        check("reset_pattern8", pattern8, 8'hFF);
        m_state = 4'hF; m_lockup = 1'b0;

        run(1'b0, 4'h0, 4'b0011, 1'b0, 16'd15, -1, -1, -1);
        check("fib_len", obs.size(), 15);
        for (int i = 0; i < 15; i++) check("fib_seq", obs[i], exp_fib[i]);

        run(1'b1, 4'h1, 4'b1100, 1'b1, 16'd15, -1, -1, -1);
        check("gal_len", obs.size(), 15);
        for (int i = 0; i < 15; i++) check("gal_seq", obs[i], exp_gal[i]);
        run(1'b0, 4'h0, 4'b1100, 1'b1, 16'd3, -1, -1, -1);
        check("gal_continue", obs[0], 4'h1);

        run(1'b1, 4'h1, 4'b0000, 1'b0, 16'd3, -1, -1, -1);
        for (int i = 0; i < 3; i++) check("lock_seq", obs[i], exp_lock[i]);
        step(); step();
        check("lock_sticky", lockup, 1);

        run(1'b0, 4'h0, 4'b0011, 1'b0, 16'd0, -1, -1, -1);
        check("lock_cleared", lockup, 0);
        run(1'b0, 4'h0, 4'b0011, 1'b0, 16'd8, 2, -1, -1);
        check("abort_count", obs.size(), 3);
        run(1'b0, 4'h0, 4'b0011, 1'b0, 16'd6, -1, 1, -1);
        check("start_ignored_count", obs.size(), 6);
        run(1'b0, 4'h0, 4'b0011, 1'b0, 16'd4, 3, -1, -1);
        run(1'b1, 4'h6, 4'b0011, 1'b0, 16'd4, -1, -1, -1);
        check("seed_start_first", obs[0], 4'h6);

        run(1'b0, 4'h0, 4'b0011, 1'b0, 16'd10, -1, -1, 4);
        check("rst_run_len", obs.size(), 5);
        run(1'b0, 4'h0, 4'b0011, 1'b0, 16'd3, -1, -1, -1);
        check("rst_restart", obs[0], 4'hF);

        for (int i = 0; i < 30; i++) begin
            bit         r_sld, r_md;
            logic [3:0] r_sd, r_p;
            logic [15:0] r_n;
            int         r_ab;
            r_sld = 1'($urandom_range(0, 1));
            r_md  = 1'($urandom_range(0, 1));
            r_sd  = 4'($urandom_range(1, 15));
            r_p   = 4'($urandom_range(0, 15));
            r_n   = 16'($urandom_range(0, 20));
            r_ab  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 20)) : -1;
            run(r_sld, r_sd, r_p, r_md, r_n, r_ab, -1, -1);
        end

        poly8 = 8'b0001_1101; num_pat8 = 16'd255; start8 = 1'b1;
        step();
        start8 = 1'b0;
        ms = 8'hFF;
        distinct = 0;
        for (int k = 0; k < 255; k++) begin
            check("w8_valid", valid8, 1);
            check("w8_pattern", pattern8, ms);
            if (pattern8 != 8'h00 && !seen[pattern8]) distinct++;
            seen[pattern8] = 1'b1;
            step();
            ms = ref_next(ms, 8'b0001_1101, 1'b0, 8);
            if (ms == 8'h00) ms = 8'hFF;
        end
        check("w8_distinct", distinct, 255);
        check("w8_wrap", pattern8, 8'hFF);
        check("w8_done", done8, 1);
        check("w8_lockup", lockup8, 0);
        step();
        check("w8_idle", busy8, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
